apb_ucpd_tx_sched: RTL and testbench

//  UCPD transmit scheduler. Sequences the half-bit clock generator enables (transmit_en, bmc_en, wait_en)

---
 rtl/apb_ucpd_pkg.sv | 17 +
 rtl/apb_ucpd_tx_arb.sv | 28 ++
 rtl/apb_ucpd_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_apb_ucpd_tx_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ucpd_pkg.sv
// UCPD transmit scheduler shared types: FSM state encoding and tx_type codes.
package apb_ucpd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_TRANSWIN = 2'b01,
    ST_ACTIVE   = 2'b10,
    ST_IFRGAP   = 2'b11
  } tx_state_e;

  typedef enum logic [1:0] {
    TX_MSG  = 2'b00,
    TX_HRST = 2'b01,
    TX_CRST = 2'b10
  } tx_type_e;

endpackage

// File: rtl/apb_ucpd_tx_arb.sv
// Fixed-priority request arbiter: pending hard reset > hard reset > cable reset > message.
module apb_ucpd_tx_arb
  import apb_ucpd_pkg::*;
(
  input  logic     msg_req_i,
  input  logic     hrst_req_i,
  input  logic     crst_req_i,
  input  logic     hrst_pend_i,
  output logic     req_vld_o,
  output tx_type_e tx_type_o
);

  always_comb begin
    req_vld_o = 1'b0;
    tx_type_o = TX_MSG;
    if (hrst_pend_i || hrst_req_i) begin
      req_vld_o = 1'b1;
      tx_type_o = TX_HRST;
    end else if (crst_req_i) begin
      req_vld_o = 1'b1;
      tx_type_o = TX_CRST;
    end else if (msg_req_i) begin
      req_vld_o = 1'b1;
      tx_type_o = TX_MSG;
    end
  end

endmodule

// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: frame sequencing, arbitration and status pulses.
// Optional frame watchdog enabled by defining UCPD_TX_WDOG_EN.
module apb_ucpd_tx_sched
  import apb_ucpd_pkg::*;
#(
  parameter int unsigned WDOG_W   = 8,
  parameter int unsigned WDOG_MAX = 200
) (
  input  logic       ic_clk,
  input  logic       ic_rst_n,
  input  logic       ucpd_en,
  input  logic       tx_msg_req,
  input  logic       tx_hrst_req,
  input  logic       tx_crst_req,
  input  logic       hbit_clk_red,
  input  logic       transwin_en,
  input  logic       ifrgap_en,
  input  logic       tx_eop_cmplt,
  output logic       transmit_en,
  output logic       bmc_en,
  output logic       wait_en,
  output logic       tx_start,
  output logic [1:0] tx_type,
  output logic       tx_busy,
  output logic       tx_msg_sent,
  output logic       tx_msg_disc,
  output logic       tx_rst_sent,
  output logic       tx_wdog_err
);

  if (WDOG_MAX < 1 || WDOG_MAX >= (1 << WDOG_W)) begin : g_wdog_cfg_bad
    $error("WDOG_MAX does not fit in WDOG_W bits");
  end

  tx_state_e state_q, state_d;
  tx_type_e  tx_type_q, tx_type_d, arb_type;
  logic      arb_vld;
  logic      hrst_pend_q, hrst_pend_d;
  logic      transwin_q, transwin_rise;
  logic      wdog_hit;
  logic      start_q, start_d, msg_sent_q, msg_sent_d, msg_disc_q, msg_disc_d;
  logic      rst_sent_q, rst_sent_d, wdog_err_q, wdog_err_d;

  apb_ucpd_tx_arb u_arb (
    .msg_req_i  (tx_msg_req),
    .hrst_req_i (tx_hrst_req),
    .crst_req_i (tx_crst_req),
    .hrst_pend_i(hrst_pend_q),
    .req_vld_o  (arb_vld),
    .tx_type_o  (arb_type)
  );

  assign transwin_rise = transwin_en & ~transwin_q;

`ifdef UCPD_TX_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // Held at zero outside ACTIVE so every frame starts counting fresh; saturates at WDOG_MAX.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (state_q != ST_ACTIVE) begin
      wdog_cnt_d = '0;
    end else if (hbit_clk_red && (wdog_cnt_q != WDOG_W'(WDOG_MAX))) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
  end

  assign wdog_hit = (state_q == ST_ACTIVE) && hbit_clk_red &&
                    (wdog_cnt_q == WDOG_W'(WDOG_MAX - 1));

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) wdog_cnt_q <= '0;
    else           wdog_cnt_q <= wdog_cnt_d;
  end
`else
  logic hbit_unused;
  assign hbit_unused = hbit_clk_red;
  assign wdog_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tx_type_d   = tx_type_q;
    hrst_pend_d = hrst_pend_q;
    start_d     = 1'b0;
    msg_sent_d  = 1'b0;
    msg_disc_d  = 1'b0;
    rst_sent_d  = 1'b0;
    wdog_err_d  = 1'b0;
    if (!ucpd_en) begin
      state_d     = ST_IDLE;
      hrst_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            state_d     = ST_TRANSWIN;
            tx_type_d   = arb_type;
            hrst_pend_d = 1'b0;
          end
        end
        ST_TRANSWIN: begin
          if (transwin_rise) begin
            start_d = 1'b1;
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Completion outranks a same-cycle hard reset; a still-held hrst_req is served from IDLE.
          if (tx_eop_cmplt) begin
            msg_sent_d = (tx_type_q == TX_MSG);
            rst_sent_d = (tx_type_q != TX_MSG);
            state_d    = ST_IFRGAP;
          end else if (tx_hrst_req && (tx_type_q == TX_MSG)) begin
            msg_disc_d  = 1'b1;
            hrst_pend_d = 1'b1;
            state_d     = ST_IFRGAP;
          end else if (wdog_hit) begin
            wdog_err_d = 1'b1;
            state_d    = ST_IFRGAP;
          end
        end
        ST_IFRGAP: begin
          if (ifrgap_en) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_q     <= ST_IDLE;
      tx_type_q   <= TX_MSG;
      hrst_pend_q <= 1'b0;
      transwin_q  <= 1'b0;
      start_q     <= 1'b0;
      msg_sent_q  <= 1'b0;
      msg_disc_q  <= 1'b0;
      rst_sent_q  <= 1'b0;
      wdog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_type_q   <= tx_type_d;
      hrst_pend_q <= hrst_pend_d;
      transwin_q  <= transwin_en;
      start_q     <= start_d;
      msg_sent_q  <= msg_sent_d;
      msg_disc_q  <= msg_disc_d;
      rst_sent_q  <= rst_sent_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign transmit_en = (state_q != ST_IDLE);
  assign tx_busy     = (state_q != ST_IDLE);
  assign bmc_en      = (state_q == ST_ACTIVE);
  assign wait_en     = (state_q == ST_IFRGAP);
  assign tx_type     = tx_type_q;
  assign tx_start    = start_q;
  assign tx_msg_sent = msg_sent_q;
  assign tx_msg_disc = msg_disc_q;
  assign tx_rst_sent = rst_sent_q;
  assign tx_wdog_err = wdog_err_q;

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Directed bench for apb_ucpd_tx_sched; watchdog cases follow UCPD_TX_WDOG_EN.
module tb_apb_ucpd_tx_sched;

  logic       ic_clk = 1'b0;
  logic       ic_rst_n = 1'b0;
  logic       ucpd_en = 1'b0;
  logic       tx_msg_req = 1'b0, tx_hrst_req = 1'b0, tx_crst_req = 1'b0;
  logic       hbit_clk_red = 1'b0, transwin_en = 1'b0, ifrgap_en = 1'b0, tx_eop_cmplt = 1'b0;
  logic       transmit_en, bmc_en, wait_en, tx_start, tx_busy;
  logic [1:0] tx_type;
  logic       tx_msg_sent, tx_msg_disc, tx_rst_sent, tx_wdog_err;

  always #5 ic_clk = ~ic_clk;

  apb_ucpd_tx_sched #(.WDOG_W(8), .WDOG_MAX(200)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpd_en(ucpd_en),
    .tx_msg_req(tx_msg_req), .tx_hrst_req(tx_hrst_req), .tx_crst_req(tx_crst_req),
    .hbit_clk_red(hbit_clk_red), .transwin_en(transwin_en), .ifrgap_en(ifrgap_en),
    .tx_eop_cmplt(tx_eop_cmplt), .transmit_en(transmit_en), .bmc_en(bmc_en),
    .wait_en(wait_en), .tx_start(tx_start), .tx_type(tx_type), .tx_busy(tx_busy),
    .tx_msg_sent(tx_msg_sent), .tx_msg_disc(tx_msg_disc), .tx_rst_sent(tx_rst_sent),
    .tx_wdog_err(tx_wdog_err)
  );

  int total = 0, bad = 0;
  int n_start = 0, n_sent = 0, n_disc = 0, n_rst = 0, n_err = 0, n_multi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses are registered, so one sample per cycle on the falling edge counts each exactly once.
  always @(negedge ic_clk) begin
    if (ic_rst_n) begin
      if (tx_start)    n_start++;
      if (tx_msg_sent) n_sent++;
      if (tx_msg_disc) n_disc++;
      if (tx_rst_sent) n_rst++;
      if (tx_wdog_err) n_err++;
      if ($countones({tx_start, tx_msg_sent, tx_msg_disc, tx_rst_sent, tx_wdog_err}) > 1) n_multi++;
    end
  end

  task automatic tick();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic go_active(input string tag);
    ticks(4);
    transwin_en = 1'b1;
    tick();
    check({tag, "_start"}, tx_start, 1);
    check({tag, "_bmc"}, bmc_en, 1);
  endtask

  task automatic eop_pulse();
    tx_eop_cmplt = 1'b1;
    tick();
    tx_eop_cmplt = 1'b0;
  endtask

  task automatic gap_done(input string tag);
    ticks(3);
    ifrgap_en = 1'b1;
    tick();
    ifrgap_en   = 1'b0;
    transwin_en = 1'b0;
    check({tag, "_idle"}, {tx_busy, transmit_en, wait_en}, 0);
  endtask

  initial begin
    ticks(2);
    check("reset_outs", {transmit_en, bmc_en, wait_en, tx_start, tx_type, tx_busy,
                         tx_msg_sent, tx_msg_disc, tx_rst_sent, tx_wdog_err}, 0);
    ic_rst_n = 1'b1;
    ucpd_en  = 1'b1;
    tick();

    // Message frame; request dropped after grant
    tx_msg_req = 1'b1;
    tick();
    check("t1_transwin", {tx_busy, transmit_en, bmc_en, wait_en}, 4'b1100);
    check("t1_type", tx_type, 0);
    tx_msg_req = 1'b0;
    go_active("t1");
    tick();
    check("t1_start_once", tx_start, 0);
    ticks(38);
    eop_pulse();
    check("t1_sent", {tx_msg_sent, wait_en, bmc_en}, 3'b110);
    tick();
    check("t1_sent_pulse_end", tx_msg_sent, 0);
    gap_done("t1");
    check("t1_counts", {n_start[7:0], n_sent[7:0]}, 16'h0101);

    // Simultaneous msg + hard reset: hard reset first, then message
    tx_msg_req  = 1'b1;
    tx_hrst_req = 1'b1;
    tick();
    check("t2_type_hrst", tx_type, 1);
    tx_hrst_req = 1'b0;
    go_active("t2a");
    ticks(5);
    eop_pulse();
    check("t2_rst_sent", {tx_rst_sent, tx_msg_sent}, 2'b10);
    gap_done("t2a");
    tick();
    check("t2_msg_grant", {tx_busy, tx_type}, 3'b100);
    tx_msg_req = 1'b0;
    go_active("t2b");
    eop_pulse();
    check("t2_msg_sent", tx_msg_sent, 1);
    gap_done("t2b");

    // Hard reset mid-message: discard, pending hrst beats a cable request
    tx_msg_req = 1'b1;
    tick();
    tx_msg_req = 1'b0;
    go_active("t3");
    ticks(9);
    tx_hrst_req = 1'b1;
    tx_crst_req = 1'b1;
    tick();
    tx_hrst_req = 1'b0;
    check("t3_disc", {tx_msg_disc, tx_msg_sent, wait_en}, 3'b101);
    tick();
    check("t3_disc_pulse_end", tx_msg_disc, 0);
    gap_done("t3");
    tick();
    check("t3_pend_type", tx_type, 1);
    tx_crst_req = 1'b0;
    go_active("t3b");
    eop_pulse();
    check("t3_rst_sent", tx_rst_sent, 1);
    gap_done("t3b");
    tick();
    check("t3_stays_idle", tx_busy, 0);

    // EOP and hard reset together: completion wins
    tx_msg_req = 1'b1;
    tick();
    tx_msg_req = 1'b0;
    go_active("t4");
    ticks(3);
    tx_eop_cmplt = 1'b1;
    tx_hrst_req  = 1'b1;
    tick();
    tx_eop_cmplt = 1'b0;
    check("t4_sent_not_disc", {tx_msg_sent, tx_msg_disc, wait_en}, 3'b101);
    gap_done("t4");
    tick();
    check("t4_hrst_type", tx_type, 1);
    tx_hrst_req = 1'b0;
    go_active("t4b");
    eop_pulse();
    check("t4_rst_sent", tx_rst_sent, 1);
    gap_done("t4b");

    // Cable reset frame
    tx_crst_req = 1'b1;
    tick();
    check("t5_type_crst", tx_type, 2);
    tx_crst_req = 1'b0;
    go_active("t5");
    eop_pulse();
    check("t5_rst_sent", tx_rst_sent, 1);
    gap_done("t5");

    // Peripheral disable in ACTIVE, with an EOP in the same cycle
    tx_msg_req = 1'b1;
    tick();
    tx_msg_req = 1'b0;
    go_active("t6");
    ticks(3);
    ucpd_en      = 1'b0;
    tx_eop_cmplt = 1'b1;
    tick();
    tx_eop_cmplt = 1'b0;
    transwin_en  = 1'b0;
    check("t6_disabled", {tx_busy, transmit_en, bmc_en, wait_en, tx_msg_sent}, 0);
    tx_msg_req = 1'b1;
    tick();
    check("t6_no_grant_disabled", tx_busy, 0);
    tx_msg_req = 1'b0;
    ucpd_en    = 1'b1;
    tick();

    // Asynchronous reset mid-frame (cable reset so tx_type is non-zero)
    tx_crst_req = 1'b1;
    tick();
    tx_crst_req = 1'b0;
    go_active("t7");
    ticks(2);
    ic_rst_n = 1'b0;
    #2;
    check("t7_async_rst", {transmit_en, bmc_en, wait_en, tx_start, tx_type, tx_busy,
                           tx_msg_sent, tx_msg_disc, tx_rst_sent, tx_wdog_err}, 0);
    transwin_en = 1'b0;
    tick();
    ic_rst_n = 1'b1;
    tick();

    // Watchdog: 199 half-bits never abort; the 200th does only when enabled
    tx_msg_req = 1'b1;
    tick();
    tx_msg_req = 1'b0;
    go_active("t8");
    repeat (199) begin
      hbit_clk_red = 1'b1;
      tick();
      hbit_clk_red = 1'b0;
      tick();
    end
    check("t8_199_no_err", {tx_wdog_err, bmc_en}, 2'b01);
    hbit_clk_red = 1'b1;
    tick();
    hbit_clk_red = 1'b0;
`ifdef UCPD_TX_WDOG_EN
    check("t8_wdog_err", {tx_wdog_err, wait_en, tx_msg_sent}, 3'b110);
    tick();
    check("t8_err_pulse_end", tx_wdog_err, 0);
    gap_done("t8");
    tx_msg_req = 1'b1;
    tick();
    tx_msg_req = 1'b0;
    go_active("t8b");
    repeat (199) begin
      hbit_clk_red = 1'b1;
      tick();
      hbit_clk_red = 1'b0;
      tick();
    end
    eop_pulse();
    check("t8b_sent_no_err", {tx_msg_sent, tx_wdog_err}, 2'b10);
    gap_done("t8b");
    check("final_err", n_err, 1);
    check("final_start", n_start, 12);
`else
    check("t8_no_wdog", {tx_wdog_err, bmc_en}, 2'b01);
    ticks(50);
    check("t8_still_active", bmc_en, 1);
    eop_pulse();
    check("t8_sent", tx_msg_sent, 1);
    gap_done("t8");
    check("final_err", n_err, 0);
    check("final_start", n_start, 11);
`endif
    check("final_sent", n_sent, 4);
    check("final_rst", n_rst, 4);
    check("final_disc", n_disc, 1);
    check("pulses_exclusive", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
